// File: rtl/flush_writer_framer_pkg.sv
// flush_writer_framer_pkg: header layout and FSM state encoding shared by the framer.
package flush_writer_framer_pkg;
    localparam int HDR_BYTES = 8;
    localparam int LEN_OFF = 0;
    localparam int OPC_OFF = 4;
    typedef logic [2:0] state_t;
    localparam state_t S_STARTUP = 3'd0;
    localparam state_t S_ACCUM = 3'd1;
    localparam state_t S_HDR = 3'd2;
    localparam state_t S_DATA = 3'd3;
    localparam state_t S_FLUSH = 3'd4;
    localparam state_t S_CLOSE = 3'd5;
    localparam state_t S_DONE = 3'd6;
endpackage

// File: rtl/flush_framer_buf.sv
// flush_framer_buf: simple dual-port message buffer with a registered 1-cycle read.
module flush_framer_buf #(
    parameter int W = 32,
    parameter int DEPTH = 1024,
    parameter int AW = 10
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] wa,
    input logic [W-1:0] wd,
    input logic [AW-1:0] ra,
    output logic [W-1:0] q
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        q <= mem[ra];
    end
endmodule

// File: rtl/flush_writer_framer.sv
// flush_writer_framer: turns a som/eom/eof message stream into flush-writer sink strobes,
// either raw pass-through or as length/opcode header followed by the buffered payload.
module flush_writer_framer
    import flush_writer_framer_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int MESSAGES_IN_FILE = 0,
    parameter int MAX_WORDS = 1024,
    parameter int AW = $clog2(MAX_WORDS)
) (
    input logic clk,
    input logic reset,
    input logic [NBYTES*8-1:0] in_data,
    input logic in_valid,
    input logic in_eom,
    input logic [7:0] in_opcode,
    input logic in_eof,
    output logic in_ready,
    output logic out_valid,
    output logic [NBYTES*8-1:0] out_data,
    output logic out_flush,
    output logic out_close,
    output logic overflow
);
    localparam int W = NBYTES * 8;
    localparam logic [AW:0] FULL = (AW+1)'(MAX_WORDS);
    localparam logic [2:0] HLAST = 3'(HDR_BYTES / NBYTES - 1);

    state_t state;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] count;
    logic [7:0] opcode;
    logic [2:0] hidx;
    logic msg_open, eof_pend, cph, wv, rv, term;
    logic [W-1:0] wd, q;
    logic [63:0] hdr;

    assign in_ready = state == S_ACCUM;
    // eof with data since the last eom closes that message as though eom arrived
    assign term = in_eom | (in_eof & (msg_open | in_valid));
    assign out_valid = wv | rv;
    assign out_data = rv ? q : wd;

    always_comb begin
        hdr = '0;
        hdr[LEN_OFF*8 +: 32] = count;
        hdr[OPC_OFF*8 +: 8] = opcode;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_STARTUP;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            opcode <= '0;
            hidx <= '0;
            msg_open <= 1'b0;
            eof_pend <= 1'b0;
            cph <= 1'b0;
            wv <= 1'b0;
            rv <= 1'b0;
            wd <= '0;
            out_flush <= 1'b0;
            out_close <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wv <= 1'b0;
            rv <= 1'b0;
            out_flush <= 1'b0;
            out_close <= 1'b0;
            case (state)
                S_STARTUP: state <= S_ACCUM;
                S_ACCUM: begin
                    if ((in_valid || in_eom) && !msg_open) opcode <= in_opcode;
                    if (in_valid) begin
                        if (MESSAGES_IN_FILE == 0) begin
                            wv <= 1'b1;
                            wd <= in_data;
                        end else if (wr_ptr == FULL) overflow <= 1'b1;
                        else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count <= count + 32'(NBYTES);
                        end
                    end
                    msg_open <= !term && (msg_open || in_valid);
                    eof_pend <= in_eof;
                    hidx <= '0;
                    rd_ptr <= '0;
                    if (term) state <= MESSAGES_IN_FILE != 0 ? S_HDR : S_FLUSH;
                    else if (in_eof) state <= S_CLOSE;
                end
                S_HDR: begin
                    wv <= 1'b1;
                    wd <= W'(hdr >> (32'(hidx) * W));
                    hidx <= hidx + 1'b1;
                    if (hidx == HLAST) state <= wr_ptr != '0 ? S_DATA : S_FLUSH;
                end
                // read issued here lands on out_data next cycle, right behind the header
                S_DATA: begin
                    rv <= 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == wr_ptr - 1'b1) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    out_flush <= 1'b1;
                    wr_ptr <= '0;
                    count <= '0;
                    state <= eof_pend ? S_CLOSE : S_ACCUM;
                end
                S_CLOSE: begin
                    out_flush <= !cph;
                    out_close <= cph;
                    cph <= 1'b1;
                    if (cph) state <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    if (MESSAGES_IN_FILE != 0) begin : g_buf
        flush_framer_buf #(.W(W), .DEPTH(MAX_WORDS), .AW(AW)) u_buf (
            .clk(clk),
            .we(in_ready && in_valid && wr_ptr != FULL),
            .wa(wr_ptr[AW-1:0]),
            .wd(in_data),
            .ra(rd_ptr[AW-1:0]),
            .q(q)
        );
    end else begin : g_nobuf
        assign q = '0;
    end
endmodule

// File: doc/flush_writer_framer.md
Name: flush_writer_framer

Overview:
- Upstream feeder for the simulation flush-writer file sink.
- Accepts a worker-style message stream (data, som/eom, opcode, eof) and converts it into the sink's per-cycle byte-lane write, flush and close strobes.
- Two modes. In raw mode, data passes straight through and each message ends with a flush.
- In message mode, each message is buffered, then emitted as an 8-byte header (length, opcode) followed by its payload, then a flush.

Parameters:
- NBYTES, 4, data width in bytes; legal values 1, 2, 4 (matches the sink).
- MESSAGES_IN_FILE, 0, 0 = raw mode, 1 = header+payload mode.
- MAX_WORDS, 1024, message buffer depth in words (message mode only).
- AW, clog2(MAX_WORDS), buffer address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NBYTES*8  payload word; lane 0 = bits 7:0 = first byte in file.
- in_valid  in  1  in_data qualifies this cycle.
- in_eom  in  1  end of message; may coincide with the last data word or stand alone (a zero-length message if no data since the last eom).
- in_opcode  in  8  opcode; sampled on the first accepted beat of a message.
- in_eof  in  1  end of stream; request file close.
- in_ready  out  1  beat (valid, eom or eof) accepted when in_ready=1.
- out_valid  out  1  write strobe to sink.
- out_data  out  NBYTES*8  write data to sink.
- out_flush  out  1  one-cycle flush strobe.
- out_close  out  1  one-cycle close strobe.
- overflow  out  1  sticky: a message exceeded MAX_WORDS.

Behaviour:
- Reset:
  - All outputs 0, FSM in STARTUP, counters 0.
- General rules:
  - The sink has no backpressure, so every out_valid cycle is consumed.
  - out_valid, out_flush and out_close are mutually exclusive in any cycle.
- STARTUP:
  - Lasts exactly one cycle after reset deasserts, while the sink opens its file.
  - in_ready=0, no outputs. Then go to ACCUM.
- ACCUM, raw mode:
  - in_ready=1.
  - An accepted valid word appears on out_valid/out_data the next cycle (1-cycle latency).
  - An accepted eom produces out_flush one cycle after the last word's out_valid. Since in_valid and in_eom may share a cycle, hold in_ready=0 for that single flush cycle.
- ACCUM, message mode:
  - in_ready=1 while the buffer is not busy draining.
  - An accepted valid word is written to buffer[wr_ptr]; wr_ptr increments.
  - The 32-bit byte count increments by NBYTES.
  - The opcode is latched on the first beat after the previous eom.
  - On accepted eom, go to HDR; in_ready=0 from the next cycle.
- HDR (message mode):
  - Emit 8/NBYTES header words back-to-back.
  - Bytes 0-3: byte count, little-endian. Byte 4: opcode. Bytes 5-7: 0.
  - Then go to DATA, or to FLUSH if the count is 0.
- DATA:
  - Read the buffer from 0 to wr_ptr-1, one word per cycle.
  - Buffer read latency is 1; out_valid is aligned to valid read data.
  - Payload continues with no gap after the last header word.
  - Go to FLUSH after the last word.
- FLUSH:
  - out_flush=1 for one cycle.
  - Clear wr_ptr and count, then return to ACCUM (or CLOSE if eof is pending).
- Overflow (message mode):
  - Words arriving when wr_ptr=MAX_WORDS are dropped and set overflow.
  - The header length reflects the stored bytes only.
  - overflow clears only on reset.
- EOF:
  - eof accepted in ACCUM is latched as pending.
  - If a message is open (data since the last eom, no eom yet), the partial message is terminated as if eom were received.
  - eom and eof in the same cycle: eom is processed first, then eof.
  - Pending eof with no open message: CLOSE.
- CLOSE:
  - out_flush=1 for one cycle, then out_close=1 for one cycle, then DONE.
- DONE:
  - in_ready=0 and all strobes 0 until reset.
- Reset mid-message or mid-drain:
  - Immediate return to STARTUP; the buffer contents are discarded.
  - No flush or close is issued.

Decomposition:
- Shared util package:
  - Header constants: HDR_BYTES=8, length byte offset 0, opcode byte offset 4.
  - FSM state enum: STARTUP, ACCUM, HDR, DATA, FLUSH, CLOSE, DONE.
- One sub-module: flush_framer_buf.
  - Simple dual-port RAM, MAX_WORDS x NBYTES*8, registered read, 1-cycle latency.
  - Instantiated only when MESSAGES_IN_FILE=1.

Test Plan:
- Raw mode, NBYTES=4:
  - Stimulus: words 0x03020100, 0x07060504, eom on the second word.
  - Required: out_valid on cycles N+1 and N+2 with the same data; out_flush on N+3; in_ready=0 on N+2 only.
- Message mode, NBYTES=4:
  - Stimulus: 3 words, opcode 0x05, eom.
  - Required: header words 0x0000000C then 0x00000005, then 3 payload words contiguous, then out_flush.
- Message mode, zero-length message:
  - Stimulus: standalone eom with opcode 0x07.
  - Required: header words 0x00000000 and 0x00000007, then flush, no payload.
- Overflow:
  - Setup: MAX_WORDS=4, NBYTES=2.
  - Stimulus: 6 words, then eom.
  - Required: header length 0x00000008, 4 payload words, overflow=1.
- EOF:
  - Stimulus: eof asserted together with the eom of a 1-word raw message.
  - Required: data, flush, flush, close on consecutive cycles; afterwards in_ready=0 and no strobes for 20 cycles.
- Reset:
  - Stimulus: reset during DATA drain.
  - Required: all outputs 0 the next cycle; in_ready=0 for the STARTUP cycle, then 1; no out_flush or out_close emitted.
